sd_spi_master: RTL and testbench

SPI master byte engine for the RK8E SD-card disk path. It generates sdCS, sdSCLK and sdMOSI and samples sdMISO. Its pins connect directly to the sdsim card model in simulation and to the SD socket on hardware. The RK8E sector-transfer controller drives it one byte or one chip-select operation at a time through a request/done handshake.

---
 rtl/sd_spi_master.sv | 174 +++++++++++++++++
 tb/tb_sd_spi_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
// SPI mode-0 master byte engine for the RK8E SD-card path.
// One XFER, CS-low, CS-high or INIT (clock-only preamble) op per request/done handshake.
module sd_spi_master #(
    parameter int unsigned SLOW_DIV   = 100,
    parameter int unsigned FAST_DIV   = 4,
    parameter int unsigned INIT_BYTES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] spiOP,
    input  logic       spiREQ,
    input  logic       spiFAST,
    input  logic [7:0] spiTXD,
    output logic [7:0] spiRXD,
    output logic       spiBUSY,
    output logic       spiDONE,
    output logic       sdCS,
    output logic       sdSCLK,
    output logic       sdMOSI,
    input  logic       sdMISO
);

    localparam logic [7:0] SlowHalf = 8'(SLOW_DIV);
    localparam logic [7:0] FastHalf = 8'(FAST_DIV);
    localparam logic [3:0] InitLast = 4'(INIT_BYTES - 1);

    localparam logic [1:0] OpXfer = 2'd0;
    localparam logic [1:0] OpCsl  = 2'd1;
    localparam logic [1:0] OpCsh  = 2'd2;
    localparam logic [1:0] OpInit = 2'd3;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] half_q, half_d;
    logic [7:0] divcnt_q, divcnt_d;
    logic [7:0] txsh_q, txsh_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic [7:0] rxd_q, rxd_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [3:0] bytecnt_q, bytecnt_d;
    logic [1:0] op_q, op_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       half_end;
    logic [7:0] tx_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            half_q    <= SlowHalf;
            divcnt_q  <= 8'd0;
            txsh_q    <= 8'hFF;
            rxsh_q    <= 8'hFF;
            rxd_q     <= 8'hFF;
            bitcnt_q  <= 3'd0;
            bytecnt_q <= 4'd0;
            op_q      <= OpXfer;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            divcnt_q  <= divcnt_d;
            txsh_q    <= txsh_d;
            rxsh_q    <= rxsh_d;
            rxd_q     <= rxd_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            op_q      <= op_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        divcnt_d  = divcnt_q;
        txsh_d    = txsh_q;
        rxsh_d    = rxsh_q;
        rxd_d     = rxd_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        op_d      = op_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        half_end  = (divcnt_q == half_q - 8'd1);
        tx_load   = (spiOP == OpInit) ? 8'hFF : spiTXD;

        case (state_q)
            StIdle: begin
                if (spiREQ) begin
                    half_d = spiFAST ? FastHalf : SlowHalf;
                    op_d   = spiOP;
                    if (spiOP == OpCsl || spiOP == OpCsh) begin
                        cs_d    = (spiOP == OpCsh);
                        state_d = StDone;
                    end else begin
                        if (spiOP == OpInit) cs_d = 1'b1;
                        txsh_d    = tx_load;
                        mosi_d    = tx_load[7];
                        bitcnt_d  = 3'd7;
                        bytecnt_d = InitLast;
                        divcnt_d  = 8'd0;
                        state_d   = StLow;
                    end
                end
            end
            StLow: begin
                if (half_end) begin
                    sclk_d   = 1'b1;
                    rxsh_d   = {rxsh_q[6:0], sdMISO};
                    divcnt_d = 8'd0;
                    state_d  = StHigh;
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            StHigh: begin
                if (half_end) begin
                    sclk_d   = 1'b0;
                    divcnt_d = 8'd0;
                    if (bitcnt_q != 3'd0) begin
                        txsh_d   = {txsh_q[6:0], 1'b1};
                        mosi_d   = txsh_q[6];
                        bitcnt_d = bitcnt_q - 3'd1;
                        state_d  = StLow;
                    end else if (op_q == OpInit && bytecnt_q != 4'd0) begin
                        bytecnt_d = bytecnt_q - 4'd1;
                        bitcnt_d  = 3'd7;
                        txsh_d    = 8'hFF;
                        mosi_d    = 1'b1;
                        state_d   = StLow;
                    end else begin
                        // Publish here so spiRXD is already valid while spiDONE is high.
                        rxd_d   = rxsh_q;
                        state_d = StDone;
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            StDone: begin
                mosi_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d = StIdle;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
            rxd_d   = 8'hFF;
        end
    end

    always_comb begin
        spiBUSY = (state_q != StIdle);
        spiDONE = (state_q == StDone);
        spiRXD  = rxd_q;
        sdCS    = cs_q;
        sdSCLK  = sclk_q;
        sdMOSI  = mosi_q;
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: loopback and a small SD-card responder drive sdMISO,
// a scoreboard of expected spiRXD/latency is consumed on each spiDONE.
module tb_sd_spi_master;

    localparam logic [1:0] OpXfer = 2'd0;
    localparam logic [1:0] OpCsl  = 2'd1;
    localparam logic [1:0] OpCsh  = 2'd2;
    localparam logic [1:0] OpInit = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [1:0] spiOP;
    logic       spiREQ;
    logic       spiFAST;
    logic [7:0] spiTXD;
    logic [7:0] spiRXD;
    logic       spiBUSY;
    logic       spiDONE;
    logic       sdCS;
    logic       sdSCLK;
    logic       sdMOSI;
    logic       sdMISO;

    int miso_sel = 2;  // 0 loopback, 1 card model, 2 tied low
    logic card_miso = 1'b1;
    assign sdMISO = (miso_sel == 0) ? sdMOSI : (miso_sel == 1) ? card_miso : 1'b0;

    sd_spi_master #(.SLOW_DIV(100), .FAST_DIV(4), .INIT_BYTES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .spiOP   (spiOP),
        .spiREQ  (spiREQ),
        .spiFAST (spiFAST),
        .spiTXD  (spiTXD),
        .spiRXD  (spiRXD),
        .spiBUSY (spiBUSY),
        .spiDONE (spiDONE),
        .sdCS    (sdCS),
        .sdSCLK  (sdSCLK),
        .sdMOSI  (sdMOSI),
        .sdMISO  (sdMISO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: one entry per accepted op.
    typedef struct {
        logic [7:0] rxd;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spiDONE) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rxd", 32'(spiRXD), 32'(e.rxd));
                check("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
    end

    // SCLK monitor: rises, MOSI at each rise, phase lengths inside an op.
    int         exp_half = 4;
    int         rises = 0;
    int         good_runs = 0;
    int         bad_runs = 0;
    int         run = 0;
    int         viol = 0;
    logic       watch = 1'b0;
    logic       have_edge = 1'b0;
    logic       sclk_m = 1'b0;
    logic [7:0] mosi_bits = 8'h00;

    always @(negedge clk) begin
        sclk_m <= sdSCLK;
        if (sdSCLK != sclk_m) begin
            if (have_edge) begin
                if (run == exp_half) good_runs <= good_runs + 1;
                else bad_runs <= bad_runs + 1;
            end
            run       <= 1;
            have_edge <= spiBUSY;
            if (sdSCLK) begin
                rises     <= rises + 1;
                mosi_bits <= {mosi_bits[6:0], sdMOSI};
            end
        end else begin
            run <= run + 1;
            if (!spiBUSY) have_edge <= 1'b0;
        end
        if (watch && spiBUSY && (sdMOSI !== 1'b1 || sdCS !== 1'b1)) viol <= viol + 1;
    end

    // Minimal SD card: answers a well-formed CMD0 with Ncr=1 filler then R1=0x01.
    logic       sclk_p = 1'b0;
    logic       fall_q = 1'b0;
    logic       fall_qq = 1'b0;
    logic [2:0] in_cnt = 3'd0;
    logic [2:0] out_cnt = 3'd0;
    logic [7:0] in_sh = 8'h00;
    logic [7:0] out_sh = 8'hFF;
    logic [2:0] cmd_idx = 3'd0;
    logic [7:0] cmd_first = 8'h00;
    logic       cmd0_ok = 1'b0;
    logic [7:0] card_byte;
    logic [7:0] resp_q[$];

    assign card_byte = {in_sh[6:0], sdMOSI};

    always @(posedge clk) begin
        sclk_p  <= sdSCLK;
        fall_q  <= ~sdSCLK & sclk_p;
        fall_qq <= fall_q;
        if (sdCS) begin
            in_cnt    <= 3'd0;
            out_cnt   <= 3'd0;
            out_sh    <= 8'hFF;
            card_miso <= 1'b1;
            cmd_idx   <= 3'd0;
        end else begin
            if (sdSCLK & ~sclk_p) begin
                in_sh  <= card_byte;
                in_cnt <= in_cnt + 3'd1;
                if (in_cnt == 3'd7 && (cmd_idx != 3'd0 || card_byte[7:6] == 2'b01)) begin
                    if (cmd_idx == 3'd0) cmd_first <= card_byte;
                    if (cmd_idx == 3'd5) begin
                        cmd_idx <= 3'd0;
                        if (cmd_first == 8'h40 && card_byte == 8'h95) begin
                            cmd0_ok <= 1'b1;
                            resp_q.push_back(8'hFF);
                            resp_q.push_back(8'h01);
                        end
                    end else begin
                        cmd_idx <= cmd_idx + 3'd1;
                    end
                end
            end
            // MISO moves three clocks after the falling edge.
            if (fall_qq) begin
                if (out_cnt == 3'd7) begin
                    out_cnt <= 3'd0;
                    if (resp_q.size() > 0) begin
                        card_miso <= resp_q[0][7];
                        out_sh    <= {resp_q[0][6:0], 1'b1};
                        void'(resp_q.pop_front());
                    end else begin
                        card_miso <= 1'b1;
                        out_sh    <= 8'hFF;
                    end
                end else begin
                    out_cnt   <= out_cnt + 3'd1;
                    card_miso <= out_sh[7];
                    out_sh    <= {out_sh[6:0], 1'b1};
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        while (spiBUSY && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (spiBUSY) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic fast, input logic [7:0] txd,
                         input logic [7:0] erxd, input int elat);
        exp_t e;
        wait_idle(20000);
        @(negedge clk);
        spiOP   = op;
        spiFAST = fast;
        spiTXD  = txd;
        spiREQ  = 1'b1;
        acc_cyc = cyc;
        e.rxd   = erxd;
        e.lat   = elat;
        sb_q.push_back(e);
        @(posedge clk);
        #1 spiREQ = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs"}, 32'(sdCS), 32'd1);
        check({tag, "_sclk"}, 32'(sdSCLK), 32'd0);
        check({tag, "_mosi"}, 32'(sdMOSI), 32'd1);
        check({tag, "_rxd"}, 32'(spiRXD), 32'hFF);
        check({tag, "_busy"}, 32'(spiBUSY), 32'd0);
        check({tag, "_done"}, 32'(spiDONE), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, g0, b0, d0, v0, n;
        reset   = 1'b1;
        clear   = 1'b0;
        spiOP   = OpXfer;
        spiREQ  = 1'b0;
        spiFAST = 1'b0;
        spiTXD  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_idle_outputs("post_reset");

        // Loopback XFER 0xA5 at fast speed.
        miso_sel = 0;
        exp_half = 4;
        r0 = rises; g0 = good_runs; b0 = bad_runs;
        do_op(OpXfer, 1'b1, 8'hA5, 8'hA5, 65);
        wait_done(200);
        check("a5_rises", 32'(rises - r0), 32'd8);
        check("a5_mosi_bits", 32'(mosi_bits), 32'hA5);
        check("a5_good_phases", 32'(good_runs - g0), 32'd15);
        check("a5_bad_phases", 32'(bad_runs - b0), 32'd0);
        @(negedge clk);
        check("a5_busy_after", 32'(spiBUSY), 32'd0);

        // INIT at slow speed.
        exp_half = 100;
        r0 = rises; g0 = good_runs; b0 = bad_runs; d0 = done_cnt; v0 = viol;
        watch = 1'b1;
        do_op(OpInit, 1'b0, 8'h00, 8'hFF, 16 * 100 * 10 + 1);
        wait_done(17000);
        watch = 1'b0;
        check("init_rises", 32'(rises - r0), 32'd80);
        check("init_cs_mosi_high", 32'(viol - v0), 32'd0);
        check("init_good_phases", 32'(good_runs - g0), 32'd159);
        check("init_bad_phases", 32'(bad_runs - b0), 32'd0);
        check("init_done_count", 32'(done_cnt - d0), 32'd1);

        // CMD0 against the card model.
        miso_sel = 1;
        exp_half = 4;
        do_op(OpCsl, 1'b1, 8'h00, 8'hFF, 1);
        wait_done(10);
        check("csl_cs", 32'(sdCS), 32'd0);
        do_op(OpXfer, 1'b1, 8'h40, 8'hFF, 65);
        for (int i = 0; i < 4; i++) do_op(OpXfer, 1'b1, 8'h00, 8'hFF, 65);
        do_op(OpXfer, 1'b1, 8'h95, 8'hFF, 65);
        do_op(OpXfer, 1'b1, 8'hFF, 8'hFF, 65);
        do_op(OpXfer, 1'b1, 8'hFF, 8'h01, 65);
        wait_done(200);
        check("cmd0_seen", 32'(cmd0_ok), 32'd1);
        do_op(OpCsh, 1'b1, 8'h00, 8'h01, 1);
        @(negedge clk);
        check("csh_cs", 32'(sdCS), 32'd1);
        wait_done(10);

        // Request while busy is ignored.
        miso_sel = 0;
        do_op(OpCsl, 1'b1, 8'h00, 8'h01, 1);
        do_op(OpXfer, 1'b1, 8'h81, 8'h81, 65);
        repeat (10) @(negedge clk);
        spiOP  = OpCsh;
        spiTXD = 8'h00;
        spiREQ = 1'b1;
        @(posedge clk);
        #1 spiREQ = 1'b0;
        wait_done(200);
        check("busy_req_cs", 32'(sdCS), 32'd0);

        // clear beats a simultaneous request.
        wait_idle(200);
        @(negedge clk);
        spiOP  = OpCsl;
        spiREQ = 1'b1;
        clear  = 1'b1;
        @(posedge clk);
        #1 spiREQ = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        check_idle_outputs("clear_req");
        repeat (5) @(negedge clk);

        // Abort mid-byte, then a clean loopback transfer.
        do_op(OpCsl, 1'b1, 8'h00, 8'hFF, 1);
        wait_done(10);
        r0 = rises; d0 = done_cnt;
        do_op(OpXfer, 1'b1, 8'h5A, 8'h5A, 65);
        n = 0;
        while ((rises - r0) < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit3", 32'(rises - r0), 32'd4);
        sb_q.delete();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (80) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_op(OpXfer, 1'b1, 8'h3C, 8'h3C, 65);
        wait_done(200);

        // Asynchronous reset mid-op.
        d0 = done_cnt;
        do_op(OpXfer, 1'b1, 8'hC3, 8'hC3, 65);
        repeat (20) @(negedge clk);
        sb_q.delete();
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("async_reset_no_done", 32'(done_cnt - d0), 32'd0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
